// File: rtl/nfc_ahb_slave_if.sv
// Purpose: AHB-Lite slave port plus NAND-core command and FIFO side-band signals of nfc_ahb_slave.
// Latency: none, this is wiring only; HCLK/HRESET are plain ports on the modules.
// Backpressure: HREADY from the slave; cmd_ready from the core; wf_empty/rf_full flags toward the core.
// slave modport:  view from nfc_ahb_slave.
// master modport: view from the bus master together with the NAND core.
interface nfc_ahb_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic        cmd_ready;
    logic        core_done;
    logic [31:0] wf_rdata;
    logic        wf_empty;
    logic        wf_pop;
    logic [31:0] rf_wdata;
    logic        rf_push;
    logic        rf_full;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP,
        output cmd_valid, cmd_opcode, cmd_addr,
        input  cmd_ready, core_done,
        output wf_rdata, wf_empty,
        input  wf_pop, rf_wdata, rf_push,
        output rf_full
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP,
        input  cmd_valid, cmd_opcode, cmd_addr,
        output cmd_ready, core_done,
        input  wf_rdata, wf_empty,
        output wf_pop, rf_wdata, rf_push,
        input  rf_full
    );
endinterface

// File: rtl/nfc_ahb_slave.sv
// Purpose: AHB-Lite register/FIFO front end of a NAND flash controller (CTRL, ADDR, STATUS, DATA).
// Latency: register accesses zero wait states; cmd_valid rises the cycle after a start write.
// Backpressure: HREADY low while DATA waits on a full write FIFO or an empty read FIFO (reads time out).
// Ports: HCLK/HRESET plain; bus (slave modport) carries AHB, command and core-side FIFO signals.

// Generic FIFO: head is visible combinationally; push+pop together always succeed.
module nfc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    // When empty, a same-cycle push flows straight to the popper.
    assign rdata   = empty ? wdata : mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

module nfc_ahb_slave #(
    parameter int FIFO_DEPTH = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic           HCLK,
    input  logic           HRESET,
    nfc_ahb_slave_if.slave bus
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [1:0] R_CTRL = 2'd0, R_ADDR = 2'd1, R_STAT = 2'd2, R_DATA = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t state, nstate, nstate_fsm;

    logic          dp_vld, dp_write;
    logic [1:0]    dp_reg;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    ctrl_op;
    logic [31:0]   addr_q, hrdata, rf_head, cmd_addr, wr_data;
    logic [7:0]    cmd_opcode;
    logic          busy, done, cmd_valid;
    logic          hready, hresp, complete;
    logic          ap, ap_err, busy_err, dp_data, wr_cmp;
    logic          wf_push, wf_full, rf_pop, rf_empty;
    logic          unused_ahb;

    assign unused_ahb = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR[31:8]};
    assign wr_data    = bus.HWDATA;

    assign ap       = bus.HSEL & bus.HTRANS[1] & hready;
    assign ap_err   = (bus.HSIZE != 3'b010) | (bus.HADDR[1:0] != 2'b00) | (bus.HADDR[7:4] != 4'h0);
    assign dp_data  = dp_vld & (dp_reg == R_DATA);
    // The start bit only exists on HWDATA, so this error is found in the data phase itself.
    assign busy_err = dp_vld & dp_write & (dp_reg == R_CTRL) & wr_data[8] & busy;

    always_comb begin
        nstate_fsm = state;
        hready     = 1'b1;
        hresp      = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dp_vld) begin
                    if (busy_err) begin
                        // First error cycle signalled from IDLE; ERR2 finishes the response.
                        hready     = 1'b0;
                        hresp      = 1'b1;
                        nstate_fsm = ERR2;
                    end else if (dp_data & ((dp_write & wf_full) | (~dp_write & rf_empty))) begin
                        hready     = 1'b0;
                        nstate_fsm = WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dp_write ? ~wf_full : ~rf_empty) begin
                    complete   = 1'b1;
                    nstate_fsm = IDLE;
                end else begin
                    hready = 1'b0;
                    // The IDLE cycle was wait 1, so tmo_cnt+1 is the current wait number.
                    if (~dp_write && (tmo_cnt >= TW'(RD_TIMEOUT - 1))) nstate_fsm = ERR1;
                end
            end
            ERR1: begin
                hready     = 1'b0;
                hresp      = 1'b1;
                nstate_fsm = ERR2;
            end
            ERR2: begin
                hresp      = 1'b1;
                nstate_fsm = IDLE;
            end
            default: nstate_fsm = IDLE;
        endcase
    end

    // Size/alignment/range errors are known at the address phase and go straight to ERR1.
    assign nstate = (ap & ap_err) ? ERR1 : nstate_fsm;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_reg   <= R_CTRL;
            tmo_cnt  <= '0;
        end else begin
            state <= nstate;
            if (hready) begin
                dp_vld <= ap & ~ap_err;
                if (ap) begin
                    dp_write <= bus.HWRITE;
                    dp_reg   <= bus.HADDR[3:2];
                end
            end
            if (nstate == WAIT && ~dp_write)
                tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : TW'(1);
            else
                tmo_cnt <= '0;
        end
    end

    assign wr_cmp  = complete & dp_write;
    assign wf_push = wr_cmp & (dp_reg == R_DATA);
    assign rf_pop  = complete & ~dp_write & (dp_reg == R_DATA);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl_op    <= '0;
            addr_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_addr   <= '0;
        end else begin
            if (cmd_valid & bus.cmd_ready) cmd_valid <= 1'b0;
            if (bus.core_done) busy <= 1'b0;
            if (wr_cmp && dp_reg == R_STAT && wr_data[1]) done <= 1'b0;
            if (bus.core_done) done <= 1'b1;   // completion beats a same-cycle W1C
            if (wr_cmp && dp_reg == R_ADDR) addr_q <= wr_data;
            if (wr_cmp && dp_reg == R_CTRL) begin
                ctrl_op <= wr_data[7:0];
                if (wr_data[8]) begin
                    busy       <= 1'b1;
                    cmd_valid  <= 1'b1;
                    cmd_opcode <= wr_data[7:0];
                    cmd_addr   <= addr_q;
                end
            end
        end
    end

    nfc_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_wf (
        .clk(HCLK), .rst(HRESET), .push(wf_push), .wdata(wr_data), .pop(bus.wf_pop),
        .rdata(bus.wf_rdata), .empty(bus.wf_empty), .full(wf_full)
    );

    nfc_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_rf (
        .clk(HCLK), .rst(HRESET), .push(bus.rf_push), .wdata(bus.rf_wdata), .pop(rf_pop),
        .rdata(rf_head), .empty(rf_empty), .full(bus.rf_full)
    );

    always_comb begin
        hrdata = '0;
        if (dp_vld & ~dp_write & ~hresp) begin
            unique case (dp_reg)
                R_CTRL:  hrdata = {24'h0, ctrl_op};
                R_ADDR:  hrdata = addr_q;
                R_STAT:  hrdata = {28'h0, wf_full, rf_empty, done, busy};
                default: hrdata = rf_head;
            endcase
        end
    end

    assign bus.HREADY     = hready;
    assign bus.HRESP      = hresp;
    assign bus.HRDATA     = hrdata;
    assign bus.cmd_valid  = cmd_valid;
    assign bus.cmd_opcode = cmd_opcode;
    assign bus.cmd_addr   = cmd_addr;
endmodule
